stopwatch_display_scan: RTL and testbench

// - Downstream consumer of the mod-60 minute/second counters. Converts minutes
//   (0-59) and seconds (0-59) to BCD and drives a 4-digit, time-multiplexed,

---
 rtl/stopwatch_display_scan.sv | 99 +++++++++
 tb/tb_stopwatch_display_scan.sv | 108 ++++++++++
 2 files changed

// File: rtl/stopwatch_display_scan.sv
// Four-digit MM:SS scanner for an active-low 7-segment display.
// Inputs are snapshotted once per frame; one field can be blinked for adjust mode.
module stopwatch_display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       blink_en,
    input  logic       blink_sel,
    output logic [3:0] an,
    output logic [6:0] seg
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    typedef struct packed {
        logic [5:0] mins;
        logic [5:0] secs;
    } snap_t;

    logic [RW-1:0] refresh_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [1:0]    idx;
    snap_t         snap;
    logic          tick;

    logic [5:0]    field;
    logic [5:0]    digit;
    logic          blank;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;

    function automatic logic [6:0] seg_code(input logic [5:0] d);
        case (d)
            6'd0:    seg_code = 7'b1000000;
            6'd1:    seg_code = 7'b1111001;
            6'd2:    seg_code = 7'b0100100;
            6'd3:    seg_code = 7'b0110000;
            6'd4:    seg_code = 7'b0011001;
            6'd5:    seg_code = 7'b0010010;
            6'd6:    seg_code = 7'b0000010;
            6'd7:    seg_code = 7'b1111000;
            6'd8:    seg_code = 7'b0000000;
            6'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    assign tick = (refresh_cnt == RW'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            refresh_cnt <= tick ? '0 : refresh_cnt + 1'b1;
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // idx[1] selects the field (0 = seconds), idx[0] selects tens over ones.
    always_comb begin
        field   = idx[1] ? snap.mins : snap.secs;
        digit   = idx[0] ? (field / 6'd10) : (field % 6'd10);
        blank   = blink_en && blink_phase && (blink_sel == idx[1]);
        an_nxt  = ~(4'b0001 << idx);
        seg_nxt = (field > 6'd59) ? 7'b0111111 : seg_code(digit);
        if (blank) begin
            an_nxt  = 4'b1111;
            seg_nxt = 7'b1111111;
        end
    end

    // The last slot of a frame still shows the old snapshot while the new one loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            an   <= 4'b1111;
            seg  <= 7'b1111111;
            idx  <= 2'd0;
            snap <= '{mins: minutes, secs: seconds};
        end else if (tick) begin
            an  <= an_nxt;
            seg <= seg_nxt;
            idx <= idx + 2'd1;
            if (idx == 2'd3)
                snap <= '{mins: minutes, secs: seconds};
        end
    end
endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Randomized bench for stopwatch_display_scan against a cycle-count based reference model.
module tb_stopwatch_display_scan;
    localparam int RD = 4;
    localparam int BD = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] minutes, seconds;
    logic       blink_en, blink_sel;
    logic [3:0] an;
    logic [6:0] seg;

    always #5 clk = ~clk;

    stopwatch_display_scan #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst), .minutes(minutes), .seconds(seconds),
        .blink_en(blink_en), .blink_sel(blink_sel), .an(an), .seg(seg)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %b expected %b", tag, $time, obs, exp);
        end
    endtask

    // Reference model: e = clock edges since reset was released.
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    int         e;
    int         sm, ss;
    logic [3:0] x_an;
    logic [6:0] x_seg;

    function automatic logic [6:0] digit_seg(input int v, input bit tens);
        if (v >= 60) return 7'b0111111;
        return tens ? seg_tab[v / 10] : seg_tab[v % 10];
    endfunction

    task automatic model_step();
        int  slot;
        bit  phase;
        bit  is_min;
        if (rst) begin
            e     = 0;
            sm    = int'(minutes);
            ss    = int'(seconds);
            x_an  = 4'b1111;
            x_seg = 7'b1111111;
        end else begin
            e++;
            phase = ((e - 1) / BD) % 2 == 1;
            if (e % RD == 0) begin
                slot   = (e / RD - 1) % 4;
                is_min = slot >= 2;
                if (blink_en && phase && (blink_sel == is_min)) begin
                    x_an  = 4'b1111;
                    x_seg = 7'b1111111;
                end else begin
                    x_an  = 4'b1111;
                    x_an[slot] = 1'b0;
                    x_seg = digit_seg(is_min ? sm : ss, slot % 2 == 1);
                end
                if (slot == 3) begin
                    sm = int'(minutes);
                    ss = int'(seconds);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("an_seg", {an, seg}, {x_an, x_seg});
        chk("an_onehot", 11'($countones(an) >= 3), 11'd1);
    endtask

    function automatic logic [5:0] rand_val();
        if ($urandom_range(9) == 0) return 6'(60 + $urandom_range(3));
        return 6'($urandom_range(59));
    endfunction

    initial begin
        rst       = 1'b1;
        minutes   = 6'd12;
        seconds   = 6'd34;
        blink_en  = 1'b0;
        blink_sel = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0) minutes = rand_val();
            if ($urandom_range(7) == 0) seconds = rand_val();
            if ($urandom_range(39) == 0) blink_en = ~blink_en;
            if ($urandom_range(59) == 0) blink_sel = ~blink_sel;
            rst = ($urandom_range(149) == 0);
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
